axi_lite_cfg_slave: RTL and testbench
=====================================

AXI_LITE_CFG_SLAVE -- requirements
Module: axi_lite_cfg_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of weight, bias and result payloads.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: width of AXI4-Lite addresses.
REQ-003 SHALL have ports, clock and reset first:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address accepted.
- s_axi_wdata  in  32  write data.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data accepted.
- s_axi_bresp  out  2  write response code.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response taken.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address accepted.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response code.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data taken.
- weight_out  out  DATA_WIDTH  weight word for the neuron array.
- weight_valid  out  1  one-cycle weight strobe.
- bias_out  out  DATA_WIDTH  bias word.
- bias_valid  out  1  one-cycle bias strobe.
- layer_num  out  32  selected layer.
- neuron_num  out  32  selected neuron.
- soft_reset  out  1  soft reset to the network.
- result_in  in  DATA_WIDTH  detected class from the network.
- result_valid  in  1  one-cycle result strobe.
- intr  out  1  result-ready interrupt, level.

Function
REQ-004 SHALL decode byte addresses [7:0]: 0x00 WEIGHT (W), 0x04 BIAS (W), 0x08 RESULT (R), 0x0C LAYER (RW), 0x10 NEURON (RW), 0x14 STATUS (R, bit0 = intr), 0x1C SOFTRST (RW, bit0).
- Any other address is unmapped.
REQ-005 Write FSM SHALL have states W_IDLE and W_RESP.
- In W_IDLE, when awvalid and wvalid are both high, assert awready and wready together for exactly one cycle, perform the register action, and go to W_RESP.
- W_RESP holds bvalid high until bready is sampled high, then returns to W_IDLE.
REQ-006 SHALL never assert awready or wready while only one of awvalid/wvalid is high.
REQ-007 bresp SHALL be 2'b00 (OKAY) for mapped writable addresses and 2'b10 (SLVERR) for unmapped or read-only addresses; writes to read-only or unmapped addresses have no side effect.
REQ-008 A write to WEIGHT SHALL drive weight_out = wdata[DATA_WIDTH-1:0] and pulse weight_valid high for exactly one cycle, the cycle after acceptance. BIAS behaves identically on bias_out/bias_valid.
REQ-009 Writes to LAYER, NEURON and SOFTRST SHALL take effect on layer_num, neuron_num and soft_reset the cycle after acceptance.
REQ-010 Read FSM SHALL have states R_IDLE and R_DATA.
- In R_IDLE, arvalid high asserts arready for one cycle, registers rdata, and goes to R_DATA.
- R_DATA holds rvalid and rdata stable until rready is sampled high.
- Read latency from arvalid to rvalid is 1 cycle.
REQ-011 rresp SHALL be OKAY with rdata zero-extended for mapped readable addresses; unmapped addresses return SLVERR with rdata = 0.
REQ-012 A result_valid pulse SHALL latch result_in into RESULT and set intr the following cycle.
REQ-013 A completed read of RESULT (rvalid and rready) SHALL clear intr.
REQ-014 If result_valid coincides with the clearing RESULT read, the new result SHALL be latched and intr SHALL remain set.
REQ-015 The read and write FSMs SHALL operate independently; simultaneous read and write are both serviced with no added latency.

Reset
REQ-016 While reset is high, at the next clock edge:
- both FSMs go to IDLE;
- all ready, valid and strobe outputs are 0;
- bresp, rresp and rdata are 0;
- layer_num, neuron_num, RESULT and intr are 0;
- soft_reset is 1.
REQ-017 reset asserted mid-transaction SHALL abort that transaction with no response issued and no strobe generated.

Configuration
REQ-018 Macro CFG_READBACK_EN:
- Defined: LAYER, NEURON and SOFTRST read back their current values.
- Undefined: those three addresses are write-only; reads of them return SLVERR with rdata = 0.
- WEIGHT and BIAS are always write-only (SLVERR on read).

Verification
REQ-019 After reset, read 0x1C -> rdata = 1 with CFG_READBACK_EN, SLVERR otherwise; write 0x1C = 0 -> soft_reset = 0, bresp OKAY.
REQ-020 Write 0x0C = 3, 0x10 = 7, then 0x00 = 0x0000ABCD -> layer_num = 3, neuron_num = 7, weight_out = 0xABCD, weight_valid high for one cycle only.
REQ-021 Hold bready low for 5 cycles after a write to 0x04 -> bvalid stays high for all 5, no second write accepted, bias_valid pulses once.
REQ-022 Pulse result_valid with result_in = 5 -> intr = 1 and 0x14 reads 1; read 0x08 -> rdata = 5, intr = 0 after the handshake.
REQ-023 Write 0x20 and read 0x00 -> both respond SLVERR and no strobe fires.
REQ-024 Assert awvalid without wvalid for 10 cycles -> awready stays 0; raise wvalid -> both readys pulse in the same cycle.

Source files
------------

// File: rtl/axi_lite_cfg_slave.sv
// AXI4-Lite configuration slave: weight/bias strobes, layer/neuron/soft-reset regs, result capture + interrupt.
// Latency: write strobes/regs update 1 cycle after AW/W acceptance; read data valid 1 cycle after AR acceptance.
// Backpressure: one outstanding write and one outstanding read; bvalid/rvalid held until bready/rready.
// Optional feature macro: CFG_READBACK_EN (LAYER, NEURON, SOFTRST become readable).
module axi_lite_cfg_slave #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  weight_valid,
    output logic [DATA_WIDTH-1:0] bias_out,
    output logic                  bias_valid,
    output logic [31:0]           layer_num,
    output logic [31:0]           neuron_num,
    output logic                  soft_reset,
    input  logic [DATA_WIDTH-1:0] result_in,
    input  logic                  result_valid,
    output logic                  intr
);

    localparam logic [7:0] ADDR_WEIGHT  = 8'h00;
    localparam logic [7:0] ADDR_BIAS    = 8'h04;
    localparam logic [7:0] ADDR_RESULT  = 8'h08;
    localparam logic [7:0] ADDR_LAYER   = 8'h0C;
    localparam logic [7:0] ADDR_NEURON  = 8'h10;
    localparam logic [7:0] ADDR_STATUS  = 8'h14;
    localparam logic [7:0] ADDR_SOFTRST = 8'h1C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t              w_state_q, w_state_d;
    r_state_t              r_state_q, r_state_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rd_result_q, rd_result_d;
    logic [DATA_WIDTH-1:0] weight_out_q, weight_out_d;
    logic                  weight_valid_q, weight_valid_d;
    logic [DATA_WIDTH-1:0] bias_out_q, bias_out_d;
    logic                  bias_valid_q, bias_valid_d;
    logic [31:0]           layer_q, layer_d;
    logic [31:0]           neuron_q, neuron_d;
    logic                  soft_reset_q, soft_reset_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  intr_q, intr_d;

    logic wr_accept;
    logic rd_accept;
    logic rd_clear;

    // Only the low address byte is decoded; upper bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:8], s_axi_araddr[ADDR_WIDTH-1:8]};

    // Handshakes: AW and W are taken together only; reset suppresses any acceptance.
    assign wr_accept = !reset && (w_state_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign rd_accept = !reset && (r_state_q == R_IDLE) && s_axi_arvalid;
    assign rd_clear  = (r_state_q == R_DATA) && s_axi_rready && rd_result_q;

    // Write FSM and register-write side effects.
    always_comb begin
        w_state_d      = w_state_q;
        bresp_d        = bresp_q;
        weight_out_d   = weight_out_q;
        weight_valid_d = 1'b0;
        bias_out_d     = bias_out_q;
        bias_valid_d   = 1'b0;
        layer_d        = layer_q;
        neuron_d       = neuron_q;
        soft_reset_d   = soft_reset_q;
        case (w_state_q)
            W_IDLE: begin
                if (wr_accept) begin
                    w_state_d = W_RESP;
                    bresp_d   = RESP_OKAY;
                    case (s_axi_awaddr[7:0])
                        ADDR_WEIGHT: begin
                            weight_out_d   = s_axi_wdata[DATA_WIDTH-1:0];
                            weight_valid_d = 1'b1;
                        end
                        ADDR_BIAS: begin
                            bias_out_d   = s_axi_wdata[DATA_WIDTH-1:0];
                            bias_valid_d = 1'b1;
                        end
                        ADDR_LAYER:   layer_d      = s_axi_wdata;
                        ADDR_NEURON:  neuron_d     = s_axi_wdata;
                        ADDR_SOFTRST: soft_reset_d = s_axi_wdata[0];
                        default:      bresp_d      = RESP_SLVERR;
                    endcase
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM: capture read data at AR acceptance, hold it until R handshake.
    always_comb begin
        r_state_d   = r_state_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        rd_result_d = rd_result_q;
        case (r_state_q)
            R_IDLE: begin
                if (rd_accept) begin
                    r_state_d   = R_DATA;
                    rresp_d     = RESP_OKAY;
                    rdata_d     = 32'd0;
                    rd_result_d = 1'b0;
                    case (s_axi_araddr[7:0])
                        ADDR_RESULT: begin
                            rdata_d     = 32'(result_q);
                            rd_result_d = 1'b1;
                        end
                        ADDR_STATUS:  rdata_d = {31'd0, intr_q};
`ifdef CFG_READBACK_EN
                        ADDR_LAYER:   rdata_d = layer_q;
                        ADDR_NEURON:  rdata_d = neuron_q;
                        ADDR_SOFTRST: rdata_d = {31'd0, soft_reset_q};
`endif
                        default:      rresp_d = RESP_SLVERR;
                    endcase
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    r_state_d   = R_IDLE;
                    rd_result_d = 1'b0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Result capture and interrupt; a new result wins over a simultaneous clearing read.
    always_comb begin
        result_d = result_q;
        intr_d   = intr_q;
        if (rd_clear) begin
            intr_d = 1'b0;
        end
        if (result_valid) begin
            result_d = result_in;
            intr_d   = 1'b1;
        end
    end

    // State registers with synchronous reset; soft_reset comes out of reset asserted.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q      <= W_IDLE;
            r_state_q      <= R_IDLE;
            bresp_q        <= 2'b00;
            rresp_q        <= 2'b00;
            rdata_q        <= 32'd0;
            rd_result_q    <= 1'b0;
            weight_out_q   <= '0;
            weight_valid_q <= 1'b0;
            bias_out_q     <= '0;
            bias_valid_q   <= 1'b0;
            layer_q        <= 32'd0;
            neuron_q       <= 32'd0;
            soft_reset_q   <= 1'b1;
            result_q       <= '0;
            intr_q         <= 1'b0;
        end else begin
            w_state_q      <= w_state_d;
            r_state_q      <= r_state_d;
            bresp_q        <= bresp_d;
            rresp_q        <= rresp_d;
            rdata_q        <= rdata_d;
            rd_result_q    <= rd_result_d;
            weight_out_q   <= weight_out_d;
            weight_valid_q <= weight_valid_d;
            bias_out_q     <= bias_out_d;
            bias_valid_q   <= bias_valid_d;
            layer_q        <= layer_d;
            neuron_q       <= neuron_d;
            soft_reset_q   <= soft_reset_d;
            result_q       <= result_d;
            intr_q         <= intr_d;
        end
    end

    assign s_axi_awready = wr_accept;
    assign s_axi_wready  = wr_accept;
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = rd_accept;
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign weight_out    = weight_out_q;
    assign weight_valid  = weight_valid_q;
    assign bias_out      = bias_out_q;
    assign bias_valid    = bias_valid_q;
    assign layer_num     = layer_q;
    assign neuron_num    = neuron_q;
    assign soft_reset    = soft_reset_q;
    assign intr          = intr_q;

endmodule

// File: tb/tb_axi_lite_cfg_slave.sv
// Directed bench for axi_lite_cfg_slave: register writes/strobes, reads, interrupt, errors, reset abort.
// Inputs driven on the falling edge; outputs sampled 1 time unit later.
// bready/rready normally held high; selected steps stall them.
module tb_axi_lite_cfg_slave;

    localparam int DW = 16;
    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] awaddr = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b1;
    logic [AW-1:0] araddr = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b1;
    logic [DW-1:0] weight_out;
    logic          weight_valid;
    logic [DW-1:0] bias_out;
    logic          bias_valid;
    logic [31:0]   layer_num;
    logic [31:0]   neuron_num;
    logic          soft_reset;
    logic [DW-1:0] result_in = '0;
    logic          result_valid = 1'b0;
    logic          intr;

    int total = 0;
    int bad   = 0;
    int wv_cnt = 0;
    int bv_cnt = 0;
    logic [DW-1:0] last_w = '0;
    logic [DW-1:0] last_b = '0;

    axi_lite_cfg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .weight_out(weight_out), .weight_valid(weight_valid),
        .bias_out(bias_out), .bias_valid(bias_valid),
        .layer_num(layer_num), .neuron_num(neuron_num), .soft_reset(soft_reset),
        .result_in(result_in), .result_valid(result_valid), .intr(intr)
    );

    always #5 clock = ~clock;

    // Count strobe cycles and remember the payload seen with each strobe.
    always @(negedge clock) begin
        if (weight_valid === 1'b1) begin
            wv_cnt <= wv_cnt + 1;
            last_w <= weight_out;
        end
        if (bias_valid === 1'b1) begin
            bv_cnt <= bv_cnt + 1;
            last_b <= bias_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full write with bready high; returns bresp.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
        bit ok;
        @(negedge clock);
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (awready === 1'b1 && wready === 1'b1) ok = 1'b1;
            else @(negedge clock);
        end
        check("wr_accept_timeout", {31'd0, ok}, 32'd1);
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (bvalid === 1'b1) ok = 1'b1;
            else @(negedge clock);
        end
        check("wr_bvalid_timeout", {31'd0, ok}, 32'd1);
        resp = bresp;
        @(negedge clock);
        #1;
    endtask

    // Full read with rready high; optionally pulses result_valid in the R handshake cycle.
    task automatic axi_read(input logic [31:0] addr, input bit pulse, input logic [DW-1:0] pval,
                            output logic [31:0] data, output logic [1:0] resp);
        bit ok;
        @(negedge clock);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (arready === 1'b1) ok = 1'b1;
            else @(negedge clock);
        end
        check("rd_accept_timeout", {31'd0, ok}, 32'd1);
        @(negedge clock);
        arvalid = 1'b0;
        if (pulse) begin
            result_in = pval; result_valid = 1'b1;
        end
        #1;
        check("rd_latency_rvalid", {31'd0, rvalid}, 32'd1);
        data = rdata;
        resp = rresp;
        @(negedge clock);
        result_valid = 1'b0;
        #1;
    endtask

    logic [1:0]  r;
    logic [31:0] d;
    int          wv0, bv0;

    initial begin
        // Reset: hold valids high to confirm nothing is accepted while in reset.
        repeat (2) @(negedge clock);
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; awaddr = 32'h00; araddr = 32'h08;
        #1;
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_strobes", {30'd0, weight_valid, bias_valid}, 32'd0);
        check("rst_bresp_rresp", {28'd0, bresp, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_layer", layer_num, 32'd0);
        check("rst_neuron", neuron_num, 32'd0);
        check("rst_soft_reset", {31'd0, soft_reset}, 32'd1);
        check("rst_intr", {31'd0, intr}, 32'd0);
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        reset = 1'b0;
        check("rst_no_strobe", wv_cnt, 32'd0);

        // Soft reset register read and clear.
        axi_read(32'h1C, 1'b0, '0, d, r);
`ifdef CFG_READBACK_EN
        check("rd_softrst_resp", {30'd0, r}, 32'd0);
        check("rd_softrst_data", d, 32'd1);
`else
        check("rd_softrst_resp", {30'd0, r}, 32'd2);
        check("rd_softrst_data", d, 32'd0);
`endif
        axi_write(32'h1C, 32'd0, r);
        check("wr_softrst_resp", {30'd0, r}, 32'd0);
        check("soft_reset_cleared", {31'd0, soft_reset}, 32'd0);

        // Layer / neuron / weight.
        axi_write(32'h0C, 32'd3, r);
        check("wr_layer_resp", {30'd0, r}, 32'd0);
        axi_write(32'h10, 32'd7, r);
        check("wr_neuron_resp", {30'd0, r}, 32'd0);
        wv0 = wv_cnt;
        axi_write(32'h00, 32'h0000ABCD, r);
        check("wr_weight_resp", {30'd0, r}, 32'd0);
        check("layer_num", layer_num, 32'd3);
        check("neuron_num", neuron_num, 32'd7);
        check("weight_out", {16'd0, last_w}, 32'h0000ABCD);
        check("weight_pulse_once", wv_cnt - wv0, 32'd1);
`ifdef CFG_READBACK_EN
        axi_read(32'h0C, 1'b0, '0, d, r);
        check("rd_layer_data", d, 32'd3);
        axi_read(32'h10, 1'b0, '0, d, r);
        check("rd_neuron_data", d, 32'd7);
`else
        axi_read(32'h0C, 1'b0, '0, d, r);
        check("rd_layer_slverr", {30'd0, r}, 32'd2);
`endif

        // Bias write with bready stalled 5 cycles; a second write is pending meanwhile.
        bv0 = bv_cnt; wv0 = wv_cnt;
        @(negedge clock);
        awaddr = 32'h04; wdata = 32'h1234; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1;
        check("bias_accept", {30'd0, awready, wready}, 32'd3);
        @(negedge clock);
        awaddr = 32'h00; wdata = 32'h5555;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_bvalid", {31'd0, bvalid}, 32'd1);
            check("stall_no_accept", {30'd0, awready, wready}, 32'd0);
            @(negedge clock);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        #1;
        check("stall_bresp", {30'd0, bresp}, 32'd0);
        @(negedge clock);
        #1;
        check("stall_bvalid_dropped", {31'd0, bvalid}, 32'd0);
        check("bias_pulse_once", bv_cnt - bv0, 32'd1);
        check("bias_out", {16'd0, last_b}, 32'h1234);
        check("stall_no_weight", wv_cnt - wv0, 32'd0);

        // Result capture, status and interrupt clear.
        @(negedge clock);
        result_in = 16'd5; result_valid = 1'b1;
        @(negedge clock);
        result_valid = 1'b0;
        #1;
        check("intr_set", {31'd0, intr}, 32'd1);
        axi_read(32'h14, 1'b0, '0, d, r);
        check("rd_status_resp", {30'd0, r}, 32'd0);
        check("rd_status_data", d, 32'd1);
        axi_read(32'h08, 1'b0, '0, d, r);
        check("rd_result_resp", {30'd0, r}, 32'd0);
        check("rd_result_data", d, 32'd5);
        check("intr_cleared", {31'd0, intr}, 32'd0);

        // New result arriving in the same cycle as the clearing read keeps intr set.
        @(negedge clock);
        result_in = 16'd9; result_valid = 1'b1;
        @(negedge clock);
        result_valid = 1'b0;
        axi_read(32'h08, 1'b1, 16'h000A, d, r);
        check("coinc_rd_data", d, 32'd9);
        check("coinc_intr_kept", {31'd0, intr}, 32'd1);
        axi_read(32'h08, 1'b0, '0, d, r);
        check("coinc_new_result", d, 32'h000A);
        check("coinc_intr_cleared", {31'd0, intr}, 32'd0);

        // Unmapped / read-only / write-only accesses.
        wv0 = wv_cnt; bv0 = bv_cnt;
        axi_write(32'h20, 32'hFFFF, r);
        check("wr_unmapped_resp", {30'd0, r}, 32'd2);
        axi_write(32'h08, 32'h1, r);
        check("wr_readonly_resp", {30'd0, r}, 32'd2);
        axi_read(32'h00, 1'b0, '0, d, r);
        check("rd_weight_resp", {30'd0, r}, 32'd2);
        check("rd_weight_data", d, 32'd0);
        axi_read(32'h18, 1'b0, '0, d, r);
        check("rd_unmapped_resp", {30'd0, r}, 32'd2);
        check("err_no_strobe", (wv_cnt - wv0) + (bv_cnt - bv0), 32'd0);
        check("err_layer_kept", layer_num, 32'd3);

        // awvalid alone must not be accepted.
        @(negedge clock);
        awaddr = 32'h10; wdata = 32'd9; awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("aw_only_no_ready", {30'd0, awready, wready}, 32'd0);
            @(negedge clock);
        end
        wvalid = 1'b1;
        #1;
        check("aw_w_ready_together", {30'd0, awready, wready}, 32'd3);
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        check("aw_w_bvalid", {31'd0, bvalid}, 32'd1);
        check("aw_w_neuron", neuron_num, 32'd9);
        @(negedge clock);

        // Simultaneous read and write.
        awaddr = 32'h0C; wdata = 32'd5; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h14; arvalid = 1'b1;
        #1;
        check("simul_readys", {29'd0, awready, wready, arready}, 32'd7);
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        #1;
        check("simul_valids", {30'd0, bvalid, rvalid}, 32'd3);
        check("simul_layer", layer_num, 32'd5);
        @(negedge clock);

        // Reset coinciding with a write request: no acceptance, no strobe.
        wv0 = wv_cnt;
        awaddr = 32'h00; wdata = 32'h7777; awvalid = 1'b1; wvalid = 1'b1; reset = 1'b1;
        #1;
        check("rst_req_no_ready", {30'd0, awready, wready}, 32'd0);
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0; reset = 1'b0;
        #1;
        check("rst_req_no_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_soft_reset_again", {31'd0, soft_reset}, 32'd1);
        check("rst_layer_cleared", layer_num, 32'd0);
        // Reset while the write response is pending drops the response.
        @(negedge clock);
        awaddr = 32'h1C; wdata = 32'd0; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        check("pend_bvalid", {31'd0, bvalid}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; bready = 1'b1;
        #1;
        check("pend_bvalid_aborted", {31'd0, bvalid}, 32'd0);
        check("rst_abort_no_strobe", wv_cnt - wv0, 32'd0);
        repeat (2) @(negedge clock);
        #1;
        check("post_abort_idle", {31'd0, bvalid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
